// File: rtl/ext_pipe.sv
// Immediate extension stage with a valid/ready handshake and a registered result.
// Define EXT_PIPE_SKID_EN to add a skid entry, giving a registered in_ready.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_err
);

  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_ext;
  logic              w_err;
  logic              w_in_xfer;
  logic              w_out_xfer;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_imm;
  logic              r_out_err;

  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
  assign w_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    w_ext = '0;
    w_err = 1'b0;
    case (in_op)
      3'd0:    w_ext = w_zext;
      3'd1:    w_ext = w_sext;
      3'd2:    w_ext = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      3'd3:    w_ext = {w_zext[DATA_W-3:0], 2'b00};
      3'd4:    w_ext = {w_sext[DATA_W-3:0], 2'b00};
      default: w_err = 1'b1;
    endcase
  end

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_err   = r_out_err;

`ifdef EXT_PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_imm;
  logic              r_skid_err;
  logic              r_in_ready;

  // r_in_ready tracks !r_skid_valid; the reset term only blanks it while reset is high.
  assign in_ready = r_in_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_out_valid || w_out_xfer) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_imm    <= r_skid_imm;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_ext;
        r_out_err   <= w_err;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      // Output is stalled: park the new item behind it.
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_ext;
      r_skid_err   <= w_err;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign in_ready = (!r_out_valid || out_ready) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_err   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_imm   <= w_ext;
      r_out_err   <= w_err;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter IMM_W, default 16, input immediate width.
REQ-002 SHALL have parameter DATA_W, default 32, output width; legal only when DATA_W >= IMM_W+2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all held and incoming items.
REQ-006 SHALL have port in_valid  input  1  upstream item present.
REQ-007 SHALL have port in_ready  output  1  block accepts an item this cycle.
REQ-008 SHALL have port in_imm  input  IMM_W  raw immediate.
REQ-009 SHALL have port in_op  input  3  extension mode.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_imm  output  DATA_W  extended result.
REQ-013 SHALL have port out_err  output  1  result came from an illegal in_op; qualified by out_valid.

Function
REQ-014 SHALL define an input transfer as in_valid && in_ready, and an output transfer as out_valid && out_ready, both sampled at the rising edge.
REQ-015 SHALL compute per op: 0 zero-extend; 1 sign-extend from in_imm[IMM_W-1]; 2 in_imm placed in the top IMM_W bits with lower bits 0; 3 zero-extend then shift left 2; 4 sign-extend then shift left 2.
REQ-016 SHALL output out_imm = 0 and out_err = 1 for ops 5-7; out_err SHALL be 0 for ops 0-4.
REQ-017 SHALL drop bits shifted past DATA_W-1 in ops 3-4; no overflow indication.
REQ-018 SHALL register results: an accepted item appears on out_valid/out_imm/out_err exactly 1 cycle after its input transfer, when the output stage is empty or drains that cycle.
REQ-019 SHALL deliver items strictly in acceptance order; no item duplicated or lost except by flush/reset.
REQ-020 SHALL hold out_imm and out_err stable while out_valid && !out_ready.
REQ-021 SHALL, on flush high, clear all valid state at that edge, not perform the output transfer, and drop any same-cycle input transfer; out_valid SHALL be 0 in the next cycle.
REQ-022 SHALL give reset priority over flush, and flush priority over transfers.
REQ-023 SHALL allow a simultaneous input and output transfer on a full output register to replace the result with no bubble.

Reset
REQ-024 SHALL, on reset, set out_valid = 0, out_imm = 0, out_err = 0 and clear every internal valid flag.
REQ-025 SHALL hold in_ready at 0 during the reset cycle; during the cycle after reset in_ready SHALL be 1.
REQ-026 SHALL let a reset asserted mid-stream discard all held items, with no output transfer in the cycle after reset.

Configuration
REQ-027 SHALL honour macro EXT_PIPE_SKID_EN.
REQ-028 With EXT_PIPE_SKID_EN defined:
- SHALL add one skid entry behind the output register.
- in_ready SHALL be a register output equal to !skid_valid, independent of out_ready in the same cycle.
- An input accepted while out_valid && !out_ready SHALL go into the skid entry.
- The skid entry SHALL move to the output register on the next output transfer.
- Sustained throughput SHALL be 1 item per cycle.
REQ-029 Without EXT_PIPE_SKID_EN:
- SHALL use only the output register.
- in_ready SHALL be (!out_valid || out_ready) && !reset, combinational from out_ready.
- Capacity SHALL be 1 item.

Verification
REQ-030 Defaults, op=1, in_imm=16'h8001, out_ready=1 -> next cycle out_valid=1, out_imm=32'hFFFF8001, out_err=0.
REQ-031 op=0, in_imm=16'h8001 -> 32'h00008001; op=2, in_imm=16'h1234 -> 32'h12340000; op=3, in_imm=16'hFFFF -> 32'h0003FFFC; op=4, in_imm=16'hFFFF -> 32'hFFFFFFFC.
REQ-032 op=6, in_imm=16'h1234 -> out_imm=0, out_err=1, one cycle later.
REQ-033 EXT_PIPE_SKID_EN defined, out_ready=0, items A=1,B=2,C=3 offered back to back -> A and B accepted, in_ready=0 while C is offered; then out_ready=1 -> A, B, C delivered on consecutive cycles.
REQ-034 Output register holding an item, out_ready=0, flush=1 together with in_valid=1 -> next cycle out_valid=0; the input is not delivered later.
REQ-035 Without the macro, out_ready=1 with continuous in_valid for 8 items -> 8 outputs on 8 consecutive cycles, in_ready=1 throughout; out_ready=0 for one cycle -> in_ready=0 in that same cycle.
